// File: rtl/fft_peak_finder_if.sv
// fft_peak_finder_if: AXI-Stream data channel carrying complex FFT bins.
interface fft_peak_finder_if #(
  parameter int DATA_WIDTH = 48
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_peak_finder.sv
// fft_peak_finder: per-frame strongest-bin search over |X|^2 of streamed complex FFT bins.
module fft_peak_finder #(
  parameter int DATA_WIDTH  = 48,
  parameter int NFFT_LOG2   = 10,
  parameter int SEARCH_BINS = 512,
  parameter int SKIP_DC     = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  fft_peak_finder_if.slave      s_axis,
  output logic [NFFT_LOG2-1:0]  peak_bin,
  output logic [DATA_WIDTH-1:0] peak_mag,
  output logic                  peak_valid,
  input  logic                  peak_ready,
  output logic                  tlast_early,
  output logic                  tlast_missing
);
  localparam int H = DATA_WIDTH / 2;
  localparam logic [NFFT_LOG2-1:0] LAST = '1;
  localparam logic [NFFT_LOG2-1:0] SD = NFFT_LOG2'(SKIP_DC);
  localparam logic [NFFT_LOG2:0] SB = (NFFT_LOG2 + 1)'(SEARCH_BINS);
  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_t;
  state_t state, state_nx;
  logic [NFFT_LOG2-1:0] cnt, b1, b2, b3, best_bin;
  logic signed [H-1:0] re1, im1;
  logic [DATA_WIDTH-1:0] sq_re, sq_im, mag3, best_mag;
  logic v1, v2, v3, l1;
  logic acc, close, take, empty, elig;
  assign acc   = s_axis.tvalid && s_axis.tready;
  assign close = acc && (s_axis.tlast || cnt == LAST);
  assign take  = peak_valid && peak_ready;
  assign empty = !(v1 || v2 || v3);
  assign elig  = v3 && b3 >= SD && {1'b0, b3} < SB;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? ACCUM :
               state == ACCUM ? (close ? FLUSH : ACCUM) :
               state == FLUSH ? (empty ? HOLD : FLUSH) :
                                (take ? ACCUM : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_axis.tready <= 1'b0;
      cnt           <= '0;
      {v1, v2, v3, l1} <= '0;
      re1 <= '0;
      im1 <= '0;
      {b1, b2, b3} <= '0;
      sq_re <= '0;
      sq_im <= '0;
      mag3  <= '0;
      best_mag <= '0;
      best_bin <= SD;
      peak_valid    <= 1'b0;
      peak_bin      <= '0;
      peak_mag      <= '0;
      tlast_early   <= 1'b0;
      tlast_missing <= 1'b0;
    end else begin
      s_axis.tready <= state_nx == ACCUM;
      if (take) cnt <= '0;
      else if (acc && !close) cnt <= cnt + NFFT_LOG2'(1);
      v1  <= acc;
      re1 <= s_axis.tdata[H-1:0];
      im1 <= s_axis.tdata[DATA_WIDTH-1:H];
      b1  <= cnt;
      l1  <= s_axis.tlast;
      v2    <= v1;
      sq_re <= DATA_WIDTH'(re1) * DATA_WIDTH'(re1);
      sq_im <= DATA_WIDTH'(im1) * DATA_WIDTH'(im1);
      b2    <= b1;
      v3   <= v2;
      mag3 <= sq_re + sq_im;
      b3   <= b2;
      // framing errors are judged from the tagged S1 beat, giving a pulse one edge after acceptance
      tlast_early   <= v1 && l1 && b1 != LAST;
      tlast_missing <= v1 && !l1 && b1 == LAST;
      if (take) begin
        best_mag <= '0;
        best_bin <= SD;
      end else if (elig && mag3 > best_mag) begin
        best_mag <= mag3;
        best_bin <= b3;
      end
      peak_valid <= state_nx == HOLD;
      if (state == FLUSH && empty) begin
        peak_bin <= best_bin;
        peak_mag <= best_mag;
      end
    end
endmodule

// File: tb/tb_fft_peak_finder.sv
// tb_fft_peak_finder: directed and randomized frames checked against an arithmetic peak-search model.
module tb_fft_peak_finder;
  localparam int DW = 48, NL = 10, N = 1024, SB = 512, SD = 1;
  logic clk = 1'b0, rst_n = 1'b0, peak_ready = 1'b0;
  logic [NL-1:0] peak_bin;
  logic [DW-1:0] peak_mag;
  logic peak_valid, tlast_early, tlast_missing;
  logic signed [23:0] re_a [N];
  logic signed [23:0] im_a [N];
  logic [NL-1:0] ob, ob2;
  logic [DW-1:0] om, om2;
  int n_pass = 0, n_chk = 0, n_fail = 0;
  fft_peak_finder_if #(.DATA_WIDTH(DW)) s_axis ();
  fft_peak_finder #(.DATA_WIDTH(DW), .NFFT_LOG2(NL), .SEARCH_BINS(SB), .SKIP_DC(SD)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .tlast_early(tlast_early), .tlast_missing(tlast_missing)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic logic signed [23:0] rnd24();
    logic signed [23:0] t;
    t = 24'($urandom);
    return t;
  endfunction
  task automatic fill(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      re_a[i] = 24'(re);
      im_a[i] = 24'(im);
    end
  endtask
  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      re_a[i] = rnd24();
      im_a[i] = rnd24();
    end
  endtask
  // peak over bins SD..min(n,SB)-1, strict '>' keeps the lowest index on ties
  task automatic model(input int n, output logic [NL-1:0] eb, output logic [DW-1:0] em);
    longint m, best;
    best = 0;
    eb = NL'(SD);
    for (int i = SD; i < n && i < SB; i++) begin
      m = longint'(re_a[i]) * re_a[i] + longint'(im_a[i]) * im_a[i];
      if (m > best) begin
        best = m;
        eb = NL'(i);
      end
    end
    em = DW'(best);
  endtask
  task automatic run_frame(input string tag, input int n, input bit last, input int gap, input int hold,
                           output logic [NL-1:0] rb, output logic [DW-1:0] rm);
    logic [NL-1:0] eb;
    logic [DW-1:0] em;
    int i, k, budget;
    bit a;
    model(n, eb, em);
    i = 0;
    budget = 0;
    while (i < n && budget < 20 * n + 100) begin
      if (gap > 0 && $urandom_range(99) < gap) s_axis.tvalid = 1'b0;
      else begin
        s_axis.tvalid = 1'b1;
        s_axis.tdata = {im_a[i], re_a[i]};
        s_axis.tlast = last && i == n - 1;
      end
      a = s_axis.tvalid && s_axis.tready;
      @(posedge clk);
      #1;
      budget++;
      if (a) i++;
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    chk({tag, "_beats"}, 64'(i), 64'(n));
    k = 0;
    while (!peak_valid && k < 12) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        chk({tag, "_early"}, 64'(tlast_early), 64'(last && n < N));
        chk({tag, "_missing"}, 64'(tlast_missing), 64'(!last && n == N));
      end
      if (k == 2) chk({tag, "_pulse_end"}, 64'({tlast_early, tlast_missing}), 64'(0));
    end
    chk({tag, "_latency"}, 64'(k), 64'(4));
    chk({tag, "_bin"}, 64'(peak_bin), 64'(eb));
    chk({tag, "_mag"}, 64'(peak_mag), 64'(em));
    rb = peak_bin;
    rm = peak_mag;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_tready"}, 64'(s_axis.tready), 64'(0));
      chk({tag, "_hold_valid"}, 64'(peak_valid), 64'(1));
      chk({tag, "_hold_bin"}, 64'(peak_bin), 64'(eb));
      chk({tag, "_hold_mag"}, 64'(peak_mag), 64'(em));
    end
    peak_ready = 1'b1;
    @(posedge clk);
    #1;
    peak_ready = 1'b0;
    chk({tag, "_taken"}, 64'(peak_valid), 64'(0));
    chk({tag, "_rearm"}, 64'(s_axis.tready), 64'(1));
  endtask
  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    s_axis.tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(s_axis.tready), 64'(0));
    chk("rst_outs", 64'({peak_valid, tlast_early, tlast_missing}), 64'(0));
    chk("rst_bin", 64'(peak_bin), 64'(0));
    chk("rst_mag", 64'(peak_mag), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_tready", 64'(s_axis.tready), 64'(1));
    fill(1, 1);
    re_a[37] = 24'sd1000;
    im_a[37] = -24'sd2000;
    run_frame("tone", N, 1'b1, 0, 0, ob, om);
    chk("tone_bin_lit", 64'(ob), 64'(37));
    chk("tone_mag_lit", 64'(om), 64'(5000000));
    fill(0, 0);
    re_a[0] = 24'sd30000;
    re_a[700] = 24'sd30000;
    {re_a[5], im_a[5], re_a[9], im_a[9]} = {4{24'sd100}};
    run_frame("ties", N, 1'b1, 0, 0, ob, om);
    chk("ties_bin_lit", 64'(ob), 64'(5));
    chk("ties_mag_lit", 64'(om), 64'(20000));
    fill_rand();
    for (int i = 0; i < 200; i++) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata = {im_a[i], re_a[i]};
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    s_axis.tvalid = 1'b0;
    #1;
    chk("midrst_tready", 64'(s_axis.tready), 64'(0));
    chk("midrst_outs", 64'({peak_valid, tlast_early, tlast_missing, peak_bin, peak_mag}), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_rel0", 64'(s_axis.tready), 64'(0));
    @(posedge clk);
    #1;
    chk("midrst_rel1", 64'(s_axis.tready), 64'(1));
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_nostale", 64'(peak_valid), 64'(0));
    fill_rand();
    run_frame("bp", N, 1'b1, 0, 50, ob, om);
    run_frame("gaps", N, 1'b1, 30, 0, ob2, om2);
    chk("gaps_same_bin", 64'(ob2), 64'(ob));
    chk("gaps_same_mag", 64'(om2), 64'(om));
    fill_rand();
    run_frame("early", 100, 1'b1, 10, 0, ob, om);
    fill_rand();
    run_frame("missing", N, 1'b0, 0, 0, ob, om);
    for (int i = 0; i < N; i++) begin
      re_a[i] = 24'($urandom_range(1000));
      im_a[i] = 24'($urandom_range(1000));
    end
    re_a[1] = 24'sd4000000;
    run_frame("next", N, 1'b1, 0, 0, ob, om);
    chk("next_bin_lit", 64'(ob), 64'(1));
    fill(0, 0);
    {re_a[3], im_a[3], re_a[0], im_a[0], re_a[600], im_a[600]} = {6{-24'sd8388608}};
    run_frame("extreme", N, 1'b1, 0, 0, ob, om);
    chk("extreme_bin_lit", 64'(ob), 64'(3));
    chk("extreme_mag_lit", 64'(om), 64'(48'h800000000000));
    fill(0, 0);
    run_frame("zero", N, 1'b1, 0, 0, ob, om);
    chk("zero_bin_lit", 64'(ob), 64'(SD));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
